mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port program/data memory (ROM region 0..ROM_SIZE-1, RAM above) between two requesters.
//  Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
//  Round-robin arbitration; sequences CS/WE/addr/in_dat into the memory and returns its registered o_dat.
//  Blocks writes into the ROM region and flags them as errors.
// PARAMETERS
//  ADDR_BITS  8    memory address width
//  DATA_BITS  8    memory data width
//  ROM_SIZE   128  first RAM address; addresses below this are read-only
// PORTS
//  CLK        in   1          system clock, all logic on posedge
//  RESET      in   1          synchronous, active-high reset
//  req0       in   1          port 0 request; held high until ack0
//  we0        in   1          port 0: 1 = write, 0 = read; stable while req0
//  addr0      in   ADDR_BITS  port 0 address; stable while req0
//  wdata0     in   DATA_BITS  port 0 write data; stable while req0
//  ack0       out  1          port 0 one-cycle completion pulse
//  err0       out  1          port 0 ROM-write error, pulses with ack0
//  rdata0     out  DATA_BITS  port 0 read data, valid while ack0 is high
//  req1, we1, addr1, wdata1, ack1, err1, rdata1: same as port 0, for port 1
//  mem_cs     out  1          to memory CS
//  mem_we     out  1          to memory WE
//  mem_addr   out  ADDR_BITS  to memory addr
//  mem_wdata  out  DATA_BITS  to memory in_dat
//  mem_rdata  in   DATA_BITS  from memory o_dat (registered in memory, 1-cycle latency)
// BEHAVIOUR
//  Reset:
//   - state=IDLE; all outputs 0 (mem_cs, mem_we, mem_addr, mem_wdata, ack*, err*, rdata*).
//   - last_winner=1, so port 0 wins the first tie.
//  FSM: IDLE -> ISSUE -> RESP -> IDLE. All outputs are registered except rdata*.
//   IDLE:
//    - samples req0/req1; no request -> stay in IDLE.
//    - One request -> that port wins.
//    - Both requesting -> the port != last_winner wins; last_winner <= winner.
//    - Latches winner, we, addr, wdata.
//    - Normal access: mem_cs <= 1, mem_we <= we, mem_addr/mem_wdata <= latched values. Go to ISSUE.
//    - ROM write (we=1 and addr < ROM_SIZE): mem_cs stays 0; set rom_err. Go to ISSUE.
//   ISSUE:
//    - Memory samples CS/WE/addr on the closing edge.
//    - mem_cs <= 0, mem_we <= 0; ack_winner <= 1; err_winner <= rom_err. Go to RESP.
//   RESP:
//    - ack/err high for exactly this cycle.
//    - rdata_winner = mem_rdata (combinational pass-through) when the access was a read; otherwise 0.
//    - The non-winning port's rdata stays 0.
//    - ack*/err* <= 0. Go to IDLE.
//  Latency and throughput:
//   - req sampled at edge N; mem_cs high in cycle N+1; ack in cycle N+2.
//   - Maximum rate: one access per 3 cycles.
//  Requester rules:
//   - A request present in IDLE is accepted; it cannot be cancelled.
//   - If req drops mid-transaction, the access still completes and ack still pulses.
//   - A request raised during ISSUE/RESP waits for the next IDLE.
//   - A req still high in the IDLE after its ack is treated as a new request.
//  Address boundaries:
//   - addr == ROM_SIZE-1 write -> err.
//   - addr == ROM_SIZE write -> normal write.
//   - Reads are allowed at any address.
//  Reset mid-operation: state -> IDLE, mem_cs/mem_we/ack/err drop on the next edge, and the pending access is discarded.
// TESTING
//  T1: reset, then req0 read addr 0x05 (ROM holds 0x3C) -> mem_cs high 1 cycle, ack0 at N+2, rdata0=0x3C, err0=0.
//  T2: req1 write 0x90 <- 0xA5, then req1 read 0x90 -> 2nd ack1 with rdata1=0xA5; mem_we high only during the write ISSUE cycle.
//  T3: req0 write 0x7F (ROM_SIZE=128) -> mem_cs never high, ack0+err0 pulse together; a later read of 0x7F returns the original ROM byte.
//  T4: req0 and req1 held continuously -> grants 0,1,0,1; acks spaced 3 cycles apart; no port is granted twice in a row.
//  T5: RESET asserted during ISSUE -> next cycle state IDLE, mem_cs=0, no ack; the requester re-requests after reset and completes normally.
//  T6: req1 read dropped after 1 cycle -> ack1 still pulses at N+2; no second access is issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory (ROM below ROM_SIZE, RAM
// above) between two requesters with round-robin arbitration.
//   CLK, RESET                  clock, synchronous active-high reset
//   req*/we*/addr*/wdata*       per-port request, held until ack*
//   ack*/err*                   per-port one-cycle completion / ROM-write error
//   rdata*                      per-port read data, combinational while ack*
//   mem_cs/mem_we/mem_addr/mem_wdata   registered memory controls
//   mem_rdata                   registered memory read data (1-cycle latency)
module mem_port_arbiter #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned ROM_SIZE  = 128
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADDR_BITS-1:0] addr0,
    input  logic [DATA_BITS-1:0] wdata0,
    output logic                 ack0,
    output logic                 err0,
    output logic [DATA_BITS-1:0] rdata0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADDR_BITS-1:0] addr1,
    input  logic [DATA_BITS-1:0] wdata1,
    output logic                 ack1,
    output logic                 err1,
    output logic [DATA_BITS-1:0] rdata1,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 last_winner_q, last_winner_d;
    logic                 winner_q, winner_d;
    logic                 we_q, we_d;
    logic                 rom_err_q, rom_err_d;
    logic                 mem_cs_q, mem_cs_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 err0_q, err0_d;
    logic                 err1_q, err1_d;

    logic                 grant1;
    logic                 sel_we;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [DATA_BITS-1:0] sel_wdata;
    logic                 rom_wr;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        winner_d      = winner_q;
        we_d          = we_q;
        rom_err_d     = rom_err_q;
        mem_cs_d      = mem_cs_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        ack0_d        = ack0_q;
        ack1_d        = ack1_q;
        err0_d        = err0_q;
        err1_d        = err1_q;

        // Port 1 wins when alone, or on a tie when port 0 won last.
        grant1    = req1 && (!req0 || !last_winner_q);
        sel_we    = grant1 ? we1    : we0;
        sel_addr  = grant1 ? addr1  : addr0;
        sel_wdata = grant1 ? wdata1 : wdata0;
        // Compare at 32 bits so ROM_SIZE == 2**ADDR_BITS still works.
        rom_wr    = sel_we && (32'(sel_addr) < ROM_SIZE);

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    winner_d      = grant1;
                    last_winner_d = grant1;
                    we_d          = sel_we;
                    rom_err_d     = rom_wr;
                    mem_cs_d      = !rom_wr;
                    mem_we_d      = sel_we && !rom_wr;
                    mem_addr_d    = sel_addr;
                    mem_wdata_d   = sel_wdata;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_cs_d = 1'b0;
                mem_we_d = 1'b0;
                ack0_d   = !winner_q;
                ack1_d   = winner_q;
                err0_d   = !winner_q && rom_err_q;
                err1_d   = winner_q && rom_err_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                err0_d  = 1'b0;
                err1_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            last_winner_q <= 1'b1;
            winner_q      <= 1'b0;
            we_q          <= 1'b0;
            rom_err_q     <= 1'b0;
            mem_cs_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            winner_q      <= winner_d;
            we_q          <= we_d;
            rom_err_q     <= rom_err_d;
            mem_cs_q      <= mem_cs_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            err0_q        <= err0_d;
            err1_q        <= err1_d;
        end
    end

    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;

    // Memory output is valid in RESP; forward it only to the winner of a read.
    assign rdata0 = (state_q == S_RESP && !winner_q && !we_q) ? mem_rdata : '0;
    assign rdata1 = (state_q == S_RESP &&  winner_q && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a
// registered-output single-port memory model (ROM contents reloaded on RESET).
module tb_mem_port_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic       ack0, err0, ack1, err1;
    logic [7:0] rdata0, rdata1;
    logic       mem_cs, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] mem [256];

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int         port;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    typedef struct {
        int         port;
        int         lat;
        logic [7:0] rd;
        logic       er;
        logic [7:0] rd_other;
        int         cs_n;
        int         we_n;
    } obs_t;

    exp_t exp_q[$];

    mem_port_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .ROM_SIZE(128)) dut (
        .CLK(CLK), .RESET(RESET),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom_byte(input int a);
        if (a == 5) return 8'h3C;
        return 8'(a * 7 + 17);
    endfunction

    // Memory model: writes anywhere it is told to, so a leaked ROM write is visible.
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 256; i++) mem[i] <= rom_byte(i);
            mem_rdata <= '0;
        end else if (mem_cs) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // Waits (bounded) for an ack, counting negedges and memory strobes seen.
    task automatic wait_ack(input int budget, output obs_t o);
        o = '{port: -1, lat: 0, rd: 8'h00, er: 1'b0, rd_other: 8'h00, cs_n: 0, we_n: 0};
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            o.lat++;
            if (mem_cs) o.cs_n++;
            if (mem_we) o.we_n++;
            if (ack0 || ack1) begin
                o.port     = (ack0 && ack1) ? 2 : (ack0 ? 0 : 1);
                o.rd       = ack0 ? rdata0 : rdata1;
                o.er       = ack0 ? err0 : err1;
                o.rd_other = ack0 ? rdata1 : rdata0;
                break;
            end
        end
    endtask

    // Raise a request in IDLE, wait for its ack, then drop it.
    task automatic do_access(input int p, input logic w, input logic [7:0] a,
                             input logic [7:0] d, output obs_t o);
        @(posedge CLK);
        #1;
        drive(p, 1'b1, w, a, d);
        wait_ack(8, o);
        drive(p, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total_cnt++;
        if ({mem_cs, mem_we, mem_addr, mem_wdata} !== 18'h0)
            $display("FAIL reset_mem got cs=%b we=%b a=%h d=%h want all 0", mem_cs, mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
        total_cnt++;
        if ({ack0, ack1, err0, err1} !== 4'b0)
            $display("FAIL reset_ack got %b want 0000", {ack0, ack1, err0, err1});
        else pass_cnt++;
        total_cnt++;
        if ({rdata0, rdata1} !== 16'h0)
            $display("FAIL reset_rdata got %h/%h want 00/00", rdata0, rdata1);
        else pass_cnt++;
        @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic test_rom_read();
        obs_t o;
        exp_t e;
        exp_q.push_back('{port: 0, rdata: 8'h3C, err: 1'b0});
        do_access(0, 1'b0, 8'h05, 8'h00, o);
        e = exp_q.pop_front();
        total_cnt++;
        if (o.port !== e.port) $display("FAIL t1_port got %0d want %0d", o.port, e.port);
        else pass_cnt++;
        total_cnt++;
        if (o.lat !== 3) $display("FAIL t1_latency got %0d want 3", o.lat);
        else pass_cnt++;
        total_cnt++;
        if (o.rd !== e.rdata || o.er !== e.err)
            $display("FAIL t1_data got rd=%h err=%b want rd=%h err=%b", o.rd, o.er, e.rdata, e.err);
        else pass_cnt++;
        total_cnt++;
        if (o.cs_n !== 1 || o.rd_other !== 8'h00)
            $display("FAIL t1_cs_other got cs_cycles=%0d rdata1=%h want 1/00", o.cs_n, o.rd_other);
        else pass_cnt++;
    endtask

    task automatic test_ram_write_read();
        obs_t o;
        exp_t e;
        exp_q.push_back('{port: 1, rdata: 8'h00, err: 1'b0});
        do_access(1, 1'b1, 8'h90, 8'hA5, o);
        e = exp_q.pop_front();
        total_cnt++;
        if (o.port !== e.port || o.rd !== e.rdata || o.er !== e.err)
            $display("FAIL t2_write got p=%0d rd=%h err=%b want p=%0d rd=%h err=%b",
                     o.port, o.rd, o.er, e.port, e.rdata, e.err);
        else pass_cnt++;
        total_cnt++;
        if (o.we_n !== 1 || o.cs_n !== 1)
            $display("FAIL t2_we_strobe got we=%0d cs=%0d want 1/1", o.we_n, o.cs_n);
        else pass_cnt++;
        exp_q.push_back('{port: 1, rdata: 8'hA5, err: 1'b0});
        do_access(1, 1'b0, 8'h90, 8'h00, o);
        e = exp_q.pop_front();
        total_cnt++;
        if (o.port !== e.port || o.rd !== e.rdata || o.lat !== 3)
            $display("FAIL t2_read got p=%0d rd=%h lat=%0d want p=%0d rd=%h lat=3",
                     o.port, o.rd, o.lat, e.port, e.rdata);
        else pass_cnt++;
        total_cnt++;
        if (o.we_n !== 0) $display("FAIL t2_read_we got %0d want 0", o.we_n);
        else pass_cnt++;
    endtask

    task automatic test_rom_boundary();
        obs_t o;
        exp_t e;
        exp_q.push_back('{port: 0, rdata: 8'h00, err: 1'b1});
        do_access(0, 1'b1, 8'h7F, 8'hEE, o);
        e = exp_q.pop_front();
        total_cnt++;
        if (o.port !== e.port || o.er !== e.err || o.rd !== e.rdata)
            $display("FAIL t3_rom_wr got p=%0d err=%b rd=%h want p=%0d err=%b rd=%h",
                     o.port, o.er, o.rd, e.port, e.err, e.rdata);
        else pass_cnt++;
        total_cnt++;
        if (o.cs_n !== 0 || o.we_n !== 0)
            $display("FAIL t3_rom_cs got cs=%0d we=%0d want 0/0", o.cs_n, o.we_n);
        else pass_cnt++;
        exp_q.push_back('{port: 0, rdata: rom_byte(8'h7F), err: 1'b0});
        do_access(0, 1'b0, 8'h7F, 8'h00, o);
        e = exp_q.pop_front();
        total_cnt++;
        if (o.rd !== e.rdata || o.er !== e.err)
            $display("FAIL t3_rom_keep got rd=%h err=%b want rd=%h err=%b", o.rd, o.er, e.rdata, e.err);
        else pass_cnt++;
        exp_q.push_back('{port: 0, rdata: 8'h00, err: 1'b0});
        do_access(0, 1'b1, 8'h80, 8'h5A, o);
        e = exp_q.pop_front();
        total_cnt++;
        if (o.er !== e.err || o.cs_n !== 1)
            $display("FAIL t3_ram_first got err=%b cs=%0d want err=%b cs=1", o.er, o.cs_n, e.err);
        else pass_cnt++;
        exp_q.push_back('{port: 0, rdata: 8'h5A, err: 1'b0});
        do_access(0, 1'b0, 8'h80, 8'h00, o);
        e = exp_q.pop_front();
        total_cnt++;
        if (o.rd !== e.rdata) $display("FAIL t3_ram_readback got %h want %h", o.rd, e.rdata);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        obs_t o;
        exp_t e;
        test_reset();
        @(posedge CLK);
        #1;
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h90, 8'h00);
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{port: k % 2, rdata: (k % 2 == 0) ? rom_byte(8'h10) : rom_byte(8'h90), err: 1'b0});
        for (int k = 0; k < 4; k++) begin
            wait_ack(8, o);
            e = exp_q.pop_front();
            total_cnt++;
            if (o.port !== e.port || o.rd !== e.rdata || o.lat !== 3)
                $display("FAIL t4_grant%0d got p=%0d rd=%h gap=%0d want p=%0d rd=%h gap=3",
                         k, o.port, o.rd, o.lat, e.port, e.rdata);
            else pass_cnt++;
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid_op();
        obs_t o;
        exp_t e;
        int   acks;
        @(posedge CLK);
        #1;
        drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
        exp_q.push_back('{port: 0, rdata: 8'h3C, err: 1'b0});
        @(negedge CLK);
        @(negedge CLK);
        total_cnt++;
        if (mem_cs !== 1'b1) $display("FAIL t5_issue_cs got %b want 1", mem_cs);
        else pass_cnt++;
        RESET = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        exp_q.delete();
        acks = 0;
        @(negedge CLK);
        total_cnt++;
        if (mem_cs !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL t5_reset_cs got cs=%b we=%b want 0/0", mem_cs, mem_we);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (ack0 || ack1) acks++;
            @(negedge CLK);
        end
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ack0 || ack1) acks++;
            @(negedge CLK);
        end
        total_cnt++;
        if (acks !== 0) $display("FAIL t5_no_ack got %0d acks want 0", acks);
        else pass_cnt++;
        exp_q.push_back('{port: 0, rdata: 8'h3C, err: 1'b0});
        do_access(0, 1'b0, 8'h05, 8'h00, o);
        e = exp_q.pop_front();
        total_cnt++;
        if (o.port !== e.port || o.rd !== e.rdata || o.lat !== 3)
            $display("FAIL t5_retry got p=%0d rd=%h lat=%0d want p=%0d rd=%h lat=3",
                     o.port, o.rd, o.lat, e.port, e.rdata);
        else pass_cnt++;
    endtask

    task automatic test_req_drop();
        obs_t o;
        exp_t e;
        int   extra_cs;
        int   extra_ack;
        @(posedge CLK);
        #1;
        drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
        exp_q.push_back('{port: 1, rdata: rom_byte(8'h20), err: 1'b0});
        @(posedge CLK);
        #1;
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_ack(8, o);
        e = exp_q.pop_front();
        total_cnt++;
        if (o.port !== e.port || o.rd !== e.rdata || o.lat !== 2)
            $display("FAIL t6_drop got p=%0d rd=%h lat=%0d want p=%0d rd=%h lat=2",
                     o.port, o.rd, o.lat, e.port, e.rdata);
        else pass_cnt++;
        extra_cs  = 0;
        extra_ack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (mem_cs) extra_cs++;
            if (ack0 || ack1) extra_ack++;
        end
        total_cnt++;
        if (extra_cs !== 0 || extra_ack !== 0)
            $display("FAIL t6_no_repeat got cs=%0d ack=%0d want 0/0", extra_cs, extra_ack);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_ram_write_read();
        test_rom_boundary();
        test_round_robin();
        test_reset_mid_op();
        test_req_drop();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
